// File: rtl/riscv_wb_arbiter.sv
// Writeback arbiter: merges LSU loads and APU results onto one regfile write port, LSU first.
// Latency: 1 cycle from selected input to registered wb_* outputs.
// Backpressure: LSU never stalled; APU gated by apu_ready_o (= buffer not full), colliding results queued in order.
module riscv_wb_arbiter #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             lsu_we_i,
    input  logic [5:0]       lsu_waddr_i,
    input  logic [31:0]      lsu_wdata_i,
    input  logic             apu_valid_i,
    input  logic [5:0]       apu_waddr_i,
    input  logic [31:0]      apu_result_i,
    output logic             apu_ready_o,
    input  logic [2:0][5:0]  rd_regs_i,
    input  logic [2:0]       rd_regs_valid_i,
    input  logic [5:0]       id_waddr_i,
    input  logic             id_waddr_valid_i,
    output logic             dep_o,
    output logic             wb_we_o,
    output logic [5:0]       wb_waddr_o,
    output logic [31:0]      wb_wdata_o,
    output logic             busy_o,
    input  logic             perf_clr_i,
    output logic [CNT_W-1:0] contention_cnt_o
);

    localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_BW = $clog2(DEPTH + 1);
    localparam logic [CNT_BW-1:0] FULL_CNT = CNT_BW'(DEPTH);

    typedef struct packed {
        logic [5:0]  waddr;
        logic [31:0] wdata;
    } wb_ent_t;

    wb_ent_t           buf_q [DEPTH];
    wb_ent_t           buf_d [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_BW-1:0] count_q, count_d;
    logic              wb_we_q, wb_we_d;
    wb_ent_t           wb_q, wb_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic             lsu_act, apu_act, empty, full, push, pop, bypass;
    logic [DEPTH-1:0] ent_vld;
    logic [PTR_W-1:0] rel;

    // Address 0 is the hardwired zero register: such writes are simply ignored.
    assign lsu_act = lsu_we_i & (lsu_waddr_i != 6'd0);
    assign empty   = (count_q == '0);
    assign full    = (count_q == FULL_CNT);
    assign apu_act = apu_valid_i & (apu_waddr_i != 6'd0) & ~full;
    assign push    = apu_act & (lsu_act | ~empty);
    assign pop     = ~lsu_act & ~empty;
    assign bypass  = apu_act & ~lsu_act & empty;

    function automatic logic src_hit(input logic [5:0]      a,
                                     input logic [2:0][5:0] rs,
                                     input logic [2:0]      rs_v,
                                     input logic [5:0]      wa,
                                     input logic            wa_v);
        logic hit;
        hit = wa_v & (wa == a);
        for (int k = 0; k < 3; k++) begin
            hit = hit | (rs_v[k] & (rs[k] == a));
        end
        return hit & (a != 6'd0);
    endfunction

    always_comb begin : next_state
        buf_d    = buf_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wb_we_d  = 1'b0;
        wb_d     = wb_q;
        cnt_d    = cnt_q;

        if (lsu_act) begin
            wb_we_d    = 1'b1;
            wb_d.waddr = lsu_waddr_i;
            wb_d.wdata = lsu_wdata_i;
        end else if (pop) begin
            wb_we_d  = 1'b1;
            wb_d     = buf_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end else if (bypass) begin
            wb_we_d    = 1'b1;
            wb_d.waddr = apu_waddr_i;
            wb_d.wdata = apu_result_i;
        end

        if (push) begin
            buf_d[wr_ptr_q].waddr = apu_waddr_i;
            buf_d[wr_ptr_q].wdata = apu_result_i;
            wr_ptr_d              = wr_ptr_q + PTR_W'(1);
        end

        if (push && !pop) begin
            count_d = count_q + CNT_BW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_BW'(1);
        end

        if (perf_clr_i) begin
            cnt_d = '0;
        end else if (push && lsu_act && !(&cnt_q)) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Hazard check covers every queued destination plus the write leaving this cycle.
    always_comb begin : hazard
        ent_vld = '0;
        rel     = '0;
        dep_o   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            rel        = PTR_W'(i) - rd_ptr_q;
            ent_vld[i] = (CNT_BW'(rel) < count_q);
            if (ent_vld[i] && src_hit(buf_q[i].waddr, rd_regs_i, rd_regs_valid_i,
                                      id_waddr_i, id_waddr_valid_i)) begin
                dep_o = 1'b1;
            end
        end
        if (wb_we_q && src_hit(wb_q.waddr, rd_regs_i, rd_regs_valid_i,
                               id_waddr_i, id_waddr_valid_i)) begin
            dep_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            wb_we_q  <= 1'b0;
            wb_q     <= '0;
            cnt_q    <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= buf_d[i];
            end
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            wb_we_q  <= wb_we_d;
            wb_q     <= wb_d;
            cnt_q    <= cnt_d;
        end
    end

    assign apu_ready_o      = ~full;
    assign wb_we_o          = wb_we_q;
    assign wb_waddr_o       = wb_q.waddr;
    assign wb_wdata_o       = wb_q.wdata;
    assign busy_o           = ~empty | wb_we_q;
    assign contention_cnt_o = cnt_q;

    // An APU result offered while full would be lost.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
        !(apu_valid_i && !apu_ready_o));

endmodule
